// File: rtl/fsqrt_issue_ctrl_pkg.sv
// rtl/fsqrt_issue_ctrl_pkg.sv - shared FPU constants, defaults and width helper
package fsqrt_issue_ctrl_pkg;

    localparam logic [31:0] POS_INF      = 32'h7F800000;
    localparam logic [31:0] ZERO         = 32'h00000000;
    localparam int          TAGW_DEFAULT = 5;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fsqrt_issue_ctrl_if.sv
// rtl/fsqrt_issue_ctrl_if.sv - request/response handshake bundle for the sqrt issue wrapper
interface fsqrt_issue_ctrl_if
    import fsqrt_issue_ctrl_pkg::*;
#(
    parameter int TAGW = TAGW_DEFAULT
);
    logic            req_valid;
    logic            req_ready;
    logic [31:0]     req_x;
    logic [TAGW-1:0] req_tag;
    logic            resp_valid;
    logic            resp_ready;
    logic [31:0]     resp_y;
    logic [TAGW-1:0] resp_tag;

    modport master (
        output req_valid, req_x, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_y, resp_tag
    );

    modport slave (
        input  req_valid, req_x, req_tag, resp_ready,
        output req_ready, resp_valid, resp_y, resp_tag
    );

endinterface

// File: rtl/fpu_result_fifo.sv
// rtl/fpu_result_fifo.sv - show-ahead in-order result FIFO shared by the FPU issue wrappers
module fpu_result_fifo
    import fsqrt_issue_ctrl_pkg::*;
#(
    parameter int W     = 37,
    parameter int DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wr_en,
    input  logic [W-1:0]          wr_data,
    input  logic                  rd_en,
    output logic [W-1:0]          rd_data,
    output logic                  rd_valid,
    output logic [clog2(DEPTH):0] count
);

    localparam int AW = clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          pop;
    logic          full;

    assign rd_valid = (count != '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign pop      = rd_en & rd_valid;
    assign rd_data  = rd_valid ? mem[rptr] : '0;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr] <= wr_data;
        end
    end

    // Pointers are AW bits wide, so DEPTH being a power of two makes them wrap for free.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (pop)   rptr <= rptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    a_no_write_when_full: assert property (@(posedge clk) disable iff (!rstn) wr_en |-> !full);

endmodule

// File: rtl/fsqrt_issue_ctrl.sv
// rtl/fsqrt_issue_ctrl.sv - issue/writeback wrapper around a fixed-latency non-stallable sqrt pipeline
module fsqrt_issue_ctrl
    import fsqrt_issue_ctrl_pkg::*;
#(
    parameter int NSTAGE = 4,
    parameter int TAGW   = TAGW_DEFAULT,
    parameter int DEPTH  = 8
) (
    input  logic                clk,
    input  logic                rstn,
    fsqrt_issue_ctrl_if.slave   ifc,
    output logic [31:0]         sq_x,
    input  logic [31:0]         sq_y,
    output logic                busy
);

    localparam int              CW       = clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   CRED_MAX = CW'(DEPTH);

    logic [CW-1:0]   cred;
    logic [CW-1:0]   fifo_count;
    logic            req_ready;
    logic            resp_valid;
    logic            accept;
    logic            pop;
    logic [NSTAGE-1:0] v;
    logic [TAGW-1:0] t [NSTAGE];
    logic [31+TAGW:0] head;

    assign req_ready     = (cred != '0);
    assign accept        = ifc.req_valid & req_ready;
    assign pop           = resp_valid & ifc.resp_ready;
    assign sq_x          = accept ? ifc.req_x : ZERO;
    assign busy          = (cred != CRED_MAX);

    assign ifc.req_ready  = req_ready;
    assign ifc.resp_valid = resp_valid;
    assign ifc.resp_y     = head[31+TAGW:TAGW];
    assign ifc.resp_tag   = head[TAGW-1:0];

    // A credit is held from accept until the result leaves the FIFO, so every op in the
    // pipe already owns a FIFO slot when it emerges.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cred <= CRED_MAX;
        end else begin
            case ({accept, pop})
                2'b10:   cred <= cred - 1'b1;
                2'b01:   cred <= cred + 1'b1;
                default: cred <= cred;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            v <= '0;
            for (int i = 0; i < NSTAGE; i++) t[i] <= '0;
        end else begin
            v    <= {v[NSTAGE-2:0], accept};
            t[0] <= ifc.req_tag;
            for (int i = 1; i < NSTAGE; i++) t[i] <= t[i-1];
        end
    end

    fpu_result_fifo #(
        .W     (32 + TAGW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .wr_en    (v[NSTAGE-1]),
        .wr_data  ({sq_y, t[NSTAGE-1]}),
        .rd_en    (ifc.resp_ready),
        .rd_data  (head),
        .rd_valid (resp_valid),
        .count    (fifo_count)
    );

    a_credit_bound: assert property (@(posedge clk) disable iff (!rstn)
        ({1'b0, cred} + {1'b0, fifo_count}) <= (CW+1)'(DEPTH));

endmodule

// File: tb/tb_fsqrt_issue_ctrl.sv
// tb/tb_fsqrt_issue_ctrl.sv - directed self-checking bench for fsqrt_issue_ctrl
module tb_fsqrt_issue_ctrl;
    import fsqrt_issue_ctrl_pkg::*;

    localparam int NSTAGE = 4;
    localparam int TAGW   = 5;
    localparam int DEPTH  = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] sq_x;
    logic [31:0] sq_y;
    logic        busy;
    int          compared = 0;
    int          mismatched = 0;

    fsqrt_issue_ctrl_if #(.TAGW(TAGW)) ifc ();

    fsqrt_issue_ctrl #(.NSTAGE(NSTAGE), .TAGW(TAGW), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .ifc  (ifc),
        .sq_x (sq_x),
        .sq_y (sq_y),
        .busy (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_sqrt(input logic [31:0] x);
        case (x)
            32'h00000000: return 32'h00000000;
            32'h3F800000: return 32'h3F800000;
            32'h40000000: return 32'h3FB504F3;
            32'h40800000: return 32'h40000000;
            32'h41100000: return 32'h40400000;
            32'h41800000: return 32'h40800000;
            32'h7F800000: return 32'h7F800000;
            default:      return 32'hFFFFFFFF;
        endcase
    endfunction

    logic [31:0] pipe [NSTAGE];
    always @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NSTAGE; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= ref_sqrt(sq_x);
            for (int i = 1; i < NSTAGE; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign sq_y = pipe[NSTAGE-1];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] sw_x [4] = '{32'h3F800000, 32'h40000000, 32'h00000000, 32'h7F800000};
    logic [31:0] sw_y [4] = '{32'h3F800000, 32'h3FB504F3, 32'h00000000, 32'h7F800000};

    initial begin
        int got, accepts, stall, first, last, order_err, seen;

        ifc.req_valid  = 1'b0;
        ifc.req_x      = '0;
        ifc.req_tag    = '0;
        ifc.resp_ready = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        #1;
        check("rst_req_ready", ifc.req_ready, 1);
        check("rst_resp_valid", ifc.resp_valid, 0);
        check("rst_resp_y", ifc.resp_y, 0);
        check("rst_resp_tag", ifc.resp_tag, 0);
        check("rst_busy", busy, 0);

        // Single op: accept in this cycle, resp_valid five cycles later.
        ifc.resp_ready = 1'b1;
        ifc.req_valid  = 1'b1;
        ifc.req_x      = 32'h40800000;
        ifc.req_tag    = 5'd3;
        #1;
        check("one_sq_x", sq_x, 32'h40800000);
        tick();
        ifc.req_valid = 1'b0;
        ifc.req_x     = 32'h40800000;
        #1;
        check("one_sq_x_idle", sq_x, 0);
        tick();
        tick();
        tick();
        check("one_not_yet", ifc.resp_valid, 0);
        check("one_busy_inflight", busy, 1);
        tick();
        check("one_valid", ifc.resp_valid, 1);
        check("one_y", ifc.resp_y, 32'h40000000);
        check("one_tag", ifc.resp_tag, 3);
        tick();
        check("one_popped", ifc.resp_valid, 0);
        check("one_busy_fall", busy, 0);

        // Back-to-back value sweep, results must come back in order.
        for (int i = 0; i < 4; i++) begin
            ifc.req_valid = 1'b1;
            ifc.req_x     = sw_x[i];
            ifc.req_tag   = TAGW'(10 + i);
            tick();
        end
        ifc.req_valid = 1'b0;
        got = 0;
        for (int k = 0; k < 12; k++) begin
            if (ifc.resp_valid && got < 4) begin
                check("sweep_y", ifc.resp_y, sw_y[got]);
                check("sweep_tag", ifc.resp_tag, 64'(10 + got));
                got++;
            end
            tick();
        end
        check("sweep_count", got, 4);

        // Backpressure: consumer stalled, producer keeps asking.
        ifc.resp_ready = 1'b0;
        ifc.req_valid  = 1'b1;
        ifc.req_x      = 32'h41100000;
        ifc.req_tag    = '0;
        accepts = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (ifc.req_ready) accepts++;
            tick();
            ifc.req_tag = TAGW'(accepts);
        end
        #1;
        check("bp_accepts", accepts, 8);
        check("bp_ready_low", ifc.req_ready, 0);
        check("bp_busy", busy, 1);
        ifc.req_valid  = 1'b0;
        ifc.resp_ready = 1'b1;
        #1;
        check("bp_ready_same_cycle", ifc.req_ready, 0);
        for (int k = 0; k < 8; k++) begin
            check("bp_valid", ifc.resp_valid, 1);
            check("bp_tag", ifc.resp_tag, 64'(k));
            check("bp_y", ifc.resp_y, 32'h40400000);
            tick();
            if (k == 0) check("bp_ready_back", ifc.req_ready, 1);
        end
        check("bp_drained", ifc.resp_valid, 0);
        check("bp_idle", busy, 0);

        // Throughput: 20 continuous requests with an always-ready consumer.
        ifc.resp_ready = 1'b1;
        accepts = 0; got = 0; stall = 0; first = -1; last = -1; order_err = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (accepts < 20) begin
                ifc.req_valid = 1'b1;
                ifc.req_x     = 32'h41800000;
                ifc.req_tag   = TAGW'(accepts);
            end else begin
                ifc.req_valid = 1'b0;
            end
            #1;
            if (ifc.req_valid && !ifc.req_ready) stall++;
            if (ifc.resp_valid) begin
                if (first < 0) first = cyc;
                last = cyc;
                if (ifc.resp_tag !== TAGW'(got) || ifc.resp_y !== 32'h40800000) order_err++;
                got++;
            end
            if (ifc.req_valid && ifc.req_ready) accepts++;
            tick();
        end
        check("tp_stalls", stall, 0);
        check("tp_count", got, 20);
        check("tp_first_latency", first, 5);
        check("tp_consecutive", last - first, 19);
        check("tp_order", order_err, 0);

        // Simultaneous accept and pop with four credits left.
        ifc.resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ifc.req_valid = 1'b1;
            ifc.req_x     = 32'h3F800000;
            ifc.req_tag   = TAGW'(20 + i);
            tick();
        end
        ifc.req_valid = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        check("sim_cred_pre", dut.cred, 4);
        check("sim_count_pre", dut.u_fifo.count, 4);
        ifc.req_valid  = 1'b1;
        ifc.req_tag    = TAGW'(24);
        ifc.resp_ready = 1'b1;
        #1;
        check("sim_head0", ifc.resp_tag, 20);
        tick();
        ifc.req_valid  = 1'b0;
        ifc.resp_ready = 1'b0;
        #1;
        check("sim_cred_both", dut.cred, 4);
        check("sim_count_pop", dut.u_fifo.count, 3);
        tick();
        tick();
        tick();
        ifc.resp_ready = 1'b1;
        #1;
        check("sim_head1", ifc.resp_tag, 21);
        tick();
        ifc.resp_ready = 1'b0;
        #1;
        check("sim_count_wr_pop", dut.u_fifo.count, 3);
        check("sim_cred_after", dut.cred, 5);
        ifc.resp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("sim_drain_tag", ifc.resp_tag, 64'(22 + k));
            tick();
        end
        check("sim_idle", busy, 0);

        // Reset while three ops are in flight.
        for (int i = 0; i < 3; i++) begin
            ifc.req_valid = 1'b1;
            ifc.req_x     = 32'h40800000;
            ifc.req_tag   = TAGW'(25 + i);
            tick();
        end
        ifc.req_valid = 1'b0;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        #1;
        check("mrst_req_ready", ifc.req_ready, 1);
        check("mrst_busy", busy, 0);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (ifc.resp_valid) seen++;
            tick();
        end
        check("mrst_no_resp", seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
